// File: rtl/cpu_mem_pkg.sv
// Shared encodings and defaults for the IF/MEM unified-memory port arbiter.
// Imported by the arbiter top and its starvation counter.
package cpu_mem_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;
    localparam state_t ST_RESP  = 2'd3;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    localparam int DEF_MEM_LAT    = 2;
    localparam int DEF_STARVE_MAX = 4;

    // Width of both the latency counter and the starvation counter (legal range 1..15).
    localparam int CNT_W = 4;

    // DM normally wins because it carries the older instruction; IF wins when alone
    // or once DM has been granted STARVE_MAX times in a row over a waiting fetch.
    function automatic logic pick_if(input logic if_req, input logic dm_req, input logic at_max);
        return if_req & (~dm_req | at_max);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Saturating counter of consecutive DM grants made while a fetch is waiting.
// Clear has priority over increment.
module starve_ctr
    import cpu_mem_pkg::*;
#(
    parameter int WIDTH = CNT_W,
    parameter int MAX   = DEF_STARVE_MAX
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_at_max
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != MAX_V)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_at_max = (r_cnt == MAX_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises IF fetches and MEM-stage loads/stores onto one fixed-latency memory port,
// returning data through registered one-cycle acks and stalling the pipeline meanwhile.
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = DEF_MEM_LAT,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic [DATA_W-1:0] o_if_rdata,
    output logic              o_if_ack,
    input  logic              i_dm_req,
    input  logic              i_dm_we,
    input  logic [ADDR_W-1:0] i_dm_addr,
    input  logic [DATA_W-1:0] i_dm_wdata,
    output logic [DATA_W-1:0] o_dm_rdata,
    output logic              o_dm_ack,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_pipe_stall,
    output logic              o_busy
);

    localparam logic [CNT_W-1:0] LAT_V = CNT_W'(MEM_LAT);

    state_t            r_state;
    state_t            w_state_next;
    logic              r_owner;
    logic              r_we;
    logic [CNT_W-1:0]  r_lat_cnt;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_if_ack;
    logic              r_dm_ack;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata;
    logic              r_busy;

    logic w_at_max;
    logic w_grant;
    logic w_grant_if;
    logic w_grant_dm_we;
    logic w_starve_inc;
    logic w_starve_clr;

    assign w_grant       = (r_state == ST_IDLE) && (i_if_req || i_dm_req);
    assign w_grant_if    = pick_if(i_if_req, i_dm_req, w_at_max);
    assign w_grant_dm_we = !w_grant_if && i_dm_we;
    assign w_starve_inc  = w_grant && !w_grant_if && i_if_req;
    assign w_starve_clr  = w_grant && w_grant_if;

    starve_ctr #(
        .WIDTH (CNT_W),
        .MAX   (STARVE_MAX)
    ) u_starve (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_inc    (w_starve_inc),
        .i_clr    (w_starve_clr),
        .o_at_max (w_at_max)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_grant) w_state_next = ST_ISSUE;
            ST_ISSUE: w_state_next = ST_WAIT;
            ST_WAIT:  if (r_lat_cnt == 4'd1) w_state_next = ST_RESP;
            ST_RESP:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_owner     <= OWN_IF;
            r_we        <= 1'b0;
            r_lat_cnt   <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_ack    <= 1'b0;
            r_dm_ack    <= 1'b0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_busy     <= (w_state_next != ST_IDLE);
            // Strobes and response data are single-cycle; they fall back to 0 by default.
            r_mem_en   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_if_ack   <= 1'b0;
            r_dm_ack   <= 1'b0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_owner     <= w_grant_if ? OWN_IF : OWN_DM;
                        r_we        <= w_grant_dm_we;
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= w_grant_dm_we;
                        r_mem_addr  <= w_grant_if ? i_if_addr : i_dm_addr;
                        r_mem_wdata <= w_grant_if ? '0 : i_dm_wdata;
                    end
                end
                ST_ISSUE: begin
                    r_lat_cnt <= LAT_V;
                end
                ST_WAIT: begin
                    r_lat_cnt <= r_lat_cnt - 4'd1;
                    // Last wait cycle: memory data is valid now, present it next cycle.
                    if (r_lat_cnt == 4'd1) begin
                        if (r_owner == OWN_IF) begin
                            r_if_ack   <= 1'b1;
                            r_if_rdata <= i_mem_rdata;
                        end else begin
                            r_dm_ack   <= 1'b1;
                            r_dm_rdata <= r_we ? '0 : i_mem_rdata;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_if_rdata  = r_if_rdata;
    assign o_if_ack    = r_if_ack;
    assign o_dm_rdata  = r_dm_rdata;
    assign o_dm_ack    = r_dm_ack;
    assign o_mem_en    = r_mem_en;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_busy      = r_busy;

    // Gated by reset so that every output reads 0 while reset is held.
    assign o_pipe_stall = i_rst_n & ((i_if_req & ~r_if_ack) | (i_dm_req & ~r_dm_ack));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: MEM_LAT=2 instance for the main scenarios,
// plus a MEM_LAT=1 instance for the short-latency case.
module tb_mem_port_arbiter;

    localparam int LAT0 = 2;
    localparam int LAT1 = 1;
    localparam int SMAX = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
    logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0, mem_rdata = '0;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic        if_ack, dm_ack, mem_en, mem_we, pipe_stall, busy;

    logic        b_if_req = 1'b0, b_dm_req = 1'b0, b_dm_we = 1'b0;
    logic [31:0] b_if_addr = '0, b_dm_addr = '0, b_dm_wdata = '0, b_mem_rdata = '0;
    logic [31:0] b_if_rdata, b_dm_rdata, b_mem_addr, b_mem_wdata;
    logic        b_if_ack, b_dm_ack, b_mem_en, b_mem_we, b_pipe_stall, b_busy;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT0), .STARVE_MAX(SMAX)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_if_req(if_req), .i_if_addr(if_addr), .o_if_rdata(if_rdata), .o_if_ack(if_ack),
        .i_dm_req(dm_req), .i_dm_we(dm_we), .i_dm_addr(dm_addr), .i_dm_wdata(dm_wdata),
        .o_dm_rdata(dm_rdata), .o_dm_ack(dm_ack),
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata), .o_pipe_stall(pipe_stall), .o_busy(busy)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT1), .STARVE_MAX(SMAX)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_if_req(b_if_req), .i_if_addr(b_if_addr), .o_if_rdata(b_if_rdata), .o_if_ack(b_if_ack),
        .i_dm_req(b_dm_req), .i_dm_we(b_dm_we), .i_dm_addr(b_dm_addr), .i_dm_wdata(b_dm_wdata),
        .o_dm_rdata(b_dm_rdata), .o_dm_ack(b_dm_ack),
        .o_mem_en(b_mem_en), .o_mem_we(b_mem_we), .o_mem_addr(b_mem_addr), .o_mem_wdata(b_mem_wdata),
        .i_mem_rdata(b_mem_rdata), .o_pipe_stall(b_pipe_stall), .o_busy(b_busy)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        int          t;
    } mem_exp_t;

    typedef struct {
        logic [31:0] data;
        int          t;
    } ack_exp_t;

    mem_exp_t exp_mem_q[$];
    ack_exp_t exp_if_q[$];
    ack_exp_t exp_dm_q[$];
    mem_exp_t b_exp_mem_q[$];
    ack_exp_t b_exp_if_q[$];
    ack_exp_t b_exp_dm_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int n_acks   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Memory contents seen by both instances: a fixed function of the address.
    function automatic logic [31:0] model_rd(input logic [31:0] a);
        if (a == 32'h0000_0010) return 32'h2002_0005;
        return (a * 32'h0001_0003) ^ 32'h5A5A_0000;
    endfunction

    function automatic mem_exp_t mk_mem(input logic [31:0] a, input logic we, input logic [31:0] wd, input int t);
        mem_exp_t e;
        e.addr = a; e.we = we; e.wdata = wd; e.t = t;
        return e;
    endfunction

    function automatic ack_exp_t mk_ack(input logic [31:0] d, input int t);
        ack_exp_t e;
        e.data = d; e.t = t;
        return e;
    endfunction

    // Memory models: read data is valid only in cycle (mem_en cycle + latency), garbage elsewhere.
    initial begin
        int          rd_cnt;
        logic [31:0] rd_val;
        rd_cnt = 0;
        rd_val = '0;
        forever begin
            @(negedge clk);
            mem_rdata = 32'hBAD0_0000 ^ 32'(cyc);
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) mem_rdata = rd_val;
            end
            if (mem_en === 1'b1) begin
                rd_val = model_rd(mem_addr);
                rd_cnt = LAT0;
            end
        end
    end

    initial begin
        int          rd_cnt;
        logic [31:0] rd_val;
        rd_cnt = 0;
        rd_val = '0;
        forever begin
            @(negedge clk);
            b_mem_rdata = 32'hBAD1_0000 ^ 32'(cyc);
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) b_mem_rdata = rd_val;
            end
            if (b_mem_en === 1'b1) begin
                rd_val = model_rd(b_mem_addr);
                rd_cnt = LAT1;
            end
        end
    end

    // Scoreboard monitors: pop and compare on every memory issue and every ack.
    initial begin
        mem_exp_t m;
        ack_exp_t a;
        forever begin
            @(negedge clk);
            if (mem_en === 1'b1) begin
                check("mem_issue_expected", 32'(exp_mem_q.size() != 0), 1);
                if (exp_mem_q.size() != 0) begin
                    m = exp_mem_q.pop_front();
                    $display("mem issue  cyc=%0d addr=0x%08h we=%0d wdata=0x%08h", cyc, mem_addr, mem_we, mem_wdata);
                    check("mem_addr", mem_addr, m.addr);
                    check("mem_we", 32'(mem_we), 32'(m.we));
                    check("mem_wdata", mem_wdata, m.wdata);
                    check("mem_en_cycle", 32'(cyc), 32'(m.t));
                end
            end
            if (if_ack === 1'b1) begin
                n_acks++;
                check("if_ack_expected", 32'(exp_if_q.size() != 0), 1);
                if (exp_if_q.size() != 0) begin
                    a = exp_if_q.pop_front();
                    $display("if ack     cyc=%0d rdata=0x%08h", cyc, if_rdata);
                    check("if_rdata", if_rdata, a.data);
                    check("if_ack_cycle", 32'(cyc), 32'(a.t));
                    check("dm_rdata_quiet", dm_rdata, 0);
                end
            end
            if (dm_ack === 1'b1) begin
                n_acks++;
                check("dm_ack_expected", 32'(exp_dm_q.size() != 0), 1);
                if (exp_dm_q.size() != 0) begin
                    a = exp_dm_q.pop_front();
                    $display("dm ack     cyc=%0d rdata=0x%08h", cyc, dm_rdata);
                    check("dm_rdata", dm_rdata, a.data);
                    check("dm_ack_cycle", 32'(cyc), 32'(a.t));
                    check("if_rdata_quiet", if_rdata, 0);
                end
            end
        end
    end

    initial begin
        mem_exp_t m;
        ack_exp_t a;
        forever begin
            @(negedge clk);
            if (b_mem_en === 1'b1) begin
                check("b_mem_issue_expected", 32'(b_exp_mem_q.size() != 0), 1);
                if (b_exp_mem_q.size() != 0) begin
                    m = b_exp_mem_q.pop_front();
                    $display("b mem issue cyc=%0d addr=0x%08h we=%0d", cyc, b_mem_addr, b_mem_we);
                    check("b_mem_addr", b_mem_addr, m.addr);
                    check("b_mem_we", 32'(b_mem_we), 32'(m.we));
                    check("b_mem_en_cycle", 32'(cyc), 32'(m.t));
                end
            end
            if (b_if_ack === 1'b1) begin
                check("b_if_ack_expected", 32'(b_exp_if_q.size() != 0), 1);
                if (b_exp_if_q.size() != 0) begin
                    a = b_exp_if_q.pop_front();
                    $display("b if ack   cyc=%0d rdata=0x%08h", cyc, b_if_rdata);
                    check("b_if_rdata", b_if_rdata, a.data);
                    check("b_if_ack_cycle", 32'(cyc), 32'(a.t));
                end
            end
            if (b_dm_ack === 1'b1) begin
                check("b_dm_ack_expected", 32'(b_exp_dm_q.size() != 0), 1);
                if (b_exp_dm_q.size() != 0) begin
                    a = b_exp_dm_q.pop_front();
                    $display("b dm ack   cyc=%0d rdata=0x%08h", cyc, b_dm_rdata);
                    check("b_dm_rdata", b_dm_rdata, a.data);
                    check("b_dm_ack_cycle", 32'(cyc), 32'(a.t));
                end
            end
        end
    end

    // Waits (bounded) for an ack: 0=IF, 1=DM on the LAT0 instance; 2=IF, 3=DM on the LAT1 instance.
    task automatic wait_ack(input int sel, input int limit);
        int   n;
        logic seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < limit) begin
            @(negedge clk);
            case (sel)
                0:       seen = if_ack;
                1:       seen = dm_ack;
                2:       seen = b_if_ack;
                default: seen = b_dm_ack;
            endcase
            n++;
        end
        check($sformatf("ack_seen_%0d", sel), 32'(seen), 1);
    endtask

    // Fetch and load rise together; DM is served first, IF right after in the next IDLE cycle.
    task automatic sim_pair(input logic [31:0] ia, input logic [31:0] da);
        int t0;
        t0 = cyc;
        if_req = 1'b1; if_addr = ia;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = da;
        exp_mem_q.push_back(mk_mem(da, 1'b0, 32'h0, t0 + 1));
        exp_mem_q.push_back(mk_mem(ia, 1'b0, 32'h0, t0 + 6));
        exp_dm_q.push_back(mk_ack(model_rd(da), t0 + 4));
        exp_if_q.push_back(mk_ack(model_rd(ia), t0 + 9));
        fork
            begin
                wait_ack(1, 20);
                @(posedge clk); #1;
                dm_req = 1'b0;
            end
            begin
                wait_ack(0, 30);
                @(posedge clk); #1;
                if_req = 1'b0;
            end
        join
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int acks_before;

        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_en", 32'(mem_en), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_if_ack", 32'(if_ack), 0);
        check("rst_dm_ack", 32'(dm_ack), 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_dm_rdata", dm_rdata, 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_b_busy", 32'(b_busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Lone fetch with stall and busy profile.
        t0 = cyc;
        if_req = 1'b1; if_addr = 32'h0000_0010;
        exp_mem_q.push_back(mk_mem(32'h10, 1'b0, 32'h0, t0 + 1));
        exp_if_q.push_back(mk_ack(32'h2002_0005, t0 + 4));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("fetch_stall_t%0d", k), 32'(pipe_stall), 1);
            check($sformatf("fetch_busy_t%0d", k), 32'(busy), (k != 0) ? 1 : 0);
        end
        @(negedge clk);
        check("fetch_ack_t4", 32'(if_ack), 1);
        check("fetch_stall_t4", 32'(pipe_stall), 0);
        @(posedge clk); #1;
        if_req = 1'b0; if_addr = '0;

        // Store.
        t0 = cyc;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'hDEAD_BEEF;
        exp_mem_q.push_back(mk_mem(32'h40, 1'b1, 32'hDEAD_BEEF, t0 + 1));
        exp_dm_q.push_back(mk_ack(32'h0, t0 + 4));
        wait_ack(1, 20);
        @(posedge clk); #1;
        dm_req = 1'b0; dm_we = 1'b0; dm_wdata = '0;

        sim_pair(32'h14, 32'h80);

        // Starvation: fetch held, DM kept requesting; four DM grants then IF wins.
        t0 = cyc;
        if_req = 1'b1; if_addr = 32'h300;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
        for (int k = 0; k < 4; k++) begin
            exp_mem_q.push_back(mk_mem(32'h200 + 32'(4 * k), 1'b0, 32'h0, t0 + 1 + 5 * k));
            exp_dm_q.push_back(mk_ack(model_rd(32'h200 + 32'(4 * k)), t0 + 4 + 5 * k));
        end
        exp_mem_q.push_back(mk_mem(32'h300, 1'b0, 32'h0, t0 + 21));
        exp_if_q.push_back(mk_ack(model_rd(32'h300), t0 + 24));
        exp_mem_q.push_back(mk_mem(32'h210, 1'b0, 32'h0, t0 + 26));
        exp_dm_q.push_back(mk_ack(model_rd(32'h210), t0 + 29));
        fork
            begin
                wait_ack(0, 60);
                @(posedge clk); #1;
                if_req = 1'b0;
            end
            begin
                for (int k = 0; k < 5; k++) begin
                    wait_ack(1, 40);
                    @(posedge clk); #1;
                    if (k < 4) dm_addr = 32'h200 + 32'(4 * (k + 1));
                    else dm_req = 1'b0;
                end
            end
        join

        // Counter was cleared by the IF grant, so DM wins the next tie again.
        sim_pair(32'h18, 32'h84);

        // Reset during WAIT: everything drops at once, no ack afterwards.
        t0 = cyc;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h88;
        exp_mem_q.push_back(mk_mem(32'h88, 1'b0, 32'h0, t0 + 1));
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("midop_busy_before", 32'(busy), 1);
        rst_n = 1'b0;
        dm_req = 1'b0;
        #1;
        check("midop_busy", 32'(busy), 0);
        check("midop_mem_en", 32'(mem_en), 0);
        check("midop_dm_ack", 32'(dm_ack), 0);
        check("midop_stall", 32'(pipe_stall), 0);
        acks_before = n_acks;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("midop_no_ack", 32'(n_acks - acks_before), 0);
        @(posedge clk); #1;
        t0 = cyc;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h8C;
        exp_mem_q.push_back(mk_mem(32'h8C, 1'b0, 32'h0, t0 + 1));
        exp_dm_q.push_back(mk_ack(model_rd(32'h8C), t0 + 4));
        wait_ack(1, 20);
        @(posedge clk); #1;
        dm_req = 1'b0;

        // MEM_LAT=1 instance: load then fetch.
        t0 = cyc;
        b_dm_req = 1'b1; b_dm_we = 1'b0; b_dm_addr = 32'h90;
        b_exp_mem_q.push_back(mk_mem(32'h90, 1'b0, 32'h0, t0 + 1));
        b_exp_dm_q.push_back(mk_ack(model_rd(32'h90), t0 + 3));
        wait_ack(3, 20);
        @(posedge clk); #1;
        b_dm_req = 1'b0;
        t0 = cyc;
        b_if_req = 1'b1; b_if_addr = 32'h0000_0010;
        b_exp_mem_q.push_back(mk_mem(32'h10, 1'b0, 32'h0, t0 + 1));
        b_exp_if_q.push_back(mk_ack(32'h2002_0005, t0 + 3));
        wait_ack(2, 20);
        @(posedge clk); #1;
        b_if_req = 1'b0;

        repeat (4) @(negedge clk);
        check("mem_q_drained", 32'(exp_mem_q.size()), 0);
        check("if_q_drained", 32'(exp_if_q.size()), 0);
        check("dm_q_drained", 32'(exp_dm_q.size()), 0);
        check("b_q_drained", 32'(b_exp_mem_q.size() + b_exp_if_q.size() + b_exp_dm_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, fixed-latency unified memory between the IF stage (instruction fetch) and the MEM stage (lw/sw) of the 5-stage pipeline CPU.
- Serialises requests with a small FSM and returns read data through registered one-cycle acks.
- Drives a stall signal that the pipeline ORs into its PC-write and IF/ID-write hold logic.

Parameters:
- ADDR_W, 32, address width in bits (byte address, passed through unchanged).
- DATA_W, 32, data width in bits.
- MEM_LAT, 2, cycles from the mem_en cycle to mem_rdata valid; legal range 1..15.
- STARVE_MAX, 4, consecutive DM grants made while if_req is pending before IF is forced to win; legal range 1..15.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held until if_ack.
- if_addr  in  ADDR_W  fetch address; stable while if_req=1.
- if_rdata  out  DATA_W  fetched instruction; valid only when if_ack=1.
- if_ack  out  1  one-cycle completion pulse for IF.
- dm_req  in  1  data request; held until dm_ack.
- dm_we  in  1  1=store (sw), 0=load (lw).
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_rdata  out  DATA_W  load data; valid only when dm_ack=1.
- dm_ack  out  1  one-cycle completion pulse for DM (loads and stores).
- mem_en  out  1  memory access strobe, one cycle per transaction.
- mem_we  out  1  memory write enable; qualified by mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en.
- pipe_stall  out  1  (if_req & ~if_ack) | (dm_req & ~dm_ack); combinational.
- busy  out  1  1 whenever state != IDLE.

Behaviour:
- Reset (reset=0): state=IDLE, all outputs 0, starve_cnt=0, owner=IF. Takes effect immediately with no clock edge. An in-flight transaction is discarded and gets no ack.
- States: IDLE, ISSUE, WAIT, RESP. All outputs except pipe_stall are registered.
- IDLE:
  - No request: stay in IDLE.
  - Any request: arbitrate, then on the next edge latch owner, address, we and wdata, and go to ISSUE.
- Arbitration:
  - DM wins by default, since it carries the older instruction.
  - IF wins if only if_req=1.
  - IF also wins if both requests are high and starve_cnt==STARVE_MAX.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) on each DM grant made while if_req=1.
  - Clears on any IF grant.
  - Holds otherwise.
- ISSUE (1 cycle):
  - mem_en=1, mem_addr=latched address.
  - mem_we=1 only when owner=DM and dm_we=1.
  - mem_wdata=latched dm_wdata, or 0 for IF.
  - Next state WAIT with lat_cnt=MEM_LAT.
- WAIT:
  - mem_en=0; lat_cnt decrements each cycle.
  - mem_rdata is sampled on the edge that ends the cycle where lat_cnt==1 (the cycle ISSUE+MEM_LAT); then go to RESP.
- RESP (1 cycle):
  - Owner's ack=1 and its rdata=captured value; the other rdata stays 0.
  - Stores also ack, with dm_rdata=0.
  - Next state IDLE.
- Latency: request seen at cycle t0 → mem_en at t1 → ack at t1+MEM_LAT+1. Minimum spacing between grants is MEM_LAT+3 cycles.
- A requester drops req in the cycle after its ack. A req still high in the IDLE cycle after RESP counts as a new request.
- A req dropped before its grant causes no transaction. A granted transaction always completes, even if its req drops.
- Both requests rising in the same cycle: arbitration as above; the loser stays stalled.
- Address and data widths pass through with no alignment check. Misaligned addresses are the memory model's concern.

Decomposition:
- Shared package cpu_mem_pkg holds:
  - state encodings ST_IDLE=2'd0, ST_ISSUE=2'd1, ST_WAIT=2'd2, ST_RESP=2'd3;
  - owner encodings OWN_IF=1'b0, OWN_DM=1'b1;
  - the default MEM_LAT and STARVE_MAX constants.
- One sub-module, starve_ctr: saturating counter with inc/clr inputs and an at_max output, width 4, asynchronous active-low reset.

Test Plan (MEM_LAT=2, STARVE_MAX=4):
- Lone fetch: if_req=1, if_addr=0x0000_0010 at t0, mem_rdata=0x2002_0005 at t3 → mem_en at t1 with mem_addr=0x10; if_ack=1 and if_rdata=0x2002_0005 at t4; pipe_stall=1 for t0..t3.
- Store: dm_req=1, dm_we=1, dm_addr=0x40, dm_wdata=0xDEAD_BEEF → mem_en=mem_we=1, mem_wdata=0xDEADBEEF at t1; dm_ack at t4 with dm_rdata=0.
- Simultaneous: if_req and dm_req (load 0x80) at t0 → DM served first (ack t4); IF granted in the IDLE cycle at t5, mem_en at t6, if_ack at t9.
- Starvation: if_req held high while dm_req is re-asserted after every ack → exactly 4 DM grants, then an IF grant although dm_req=1; starve_cnt returns to 0.
- Reset mid-op: reset=0 in WAIT (t2) → mem_en, busy and acks go to 0 at once; no ack for 3 cycles after release; the next request is served normally.
- MEM_LAT=1 rebuild: load at t0 → mem_en at t1, rdata sampled end of t2, dm_ack at t3.
